// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and state encoding for the IMEM loader
package imem_loader_pkg;

    localparam int IMEM_WORDS_DEF  = 256;
    localparam int ADDR_W_DEF      = 8;
    localparam int FRAME_HDR_BYTES = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN0  = 3'd1;
    localparam logic [2:0] ST_LEN1  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LEN0  = ST_LEN0,
        LEN1  = ST_LEN1,
        DATA  = ST_DATA,
        CSUM  = ST_CSUM,
        DONE  = ST_DONE,
        ERROR = ST_ERROR
    } load_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// rtl/imem_word_assembler.sv - packs little-endian bytes into 32-bit words
module imem_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  lane;
    logic [23:0] shreg;

    // Fourth byte completes the word combinationally; the loader registers it.
    assign word_valid = byte_valid && (lane == 2'd3);
    assign word_data  = {byte_data, shreg};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane  <= 2'd0;
            shreg <= 24'd0;
        end else if (byte_valid) begin
            lane  <= lane + 2'd1;
            shreg <= {byte_data, shreg[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader writing IMEM and gating CPU reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    load_state_t     state, state_n;
    logic [7:0]      xor_acc;
    logic [7:0]      len_lo;
    logic [ADDR_W:0] len_words;
    logic [15:0]     frame_len;
    logic            accept;
    logic            start_load;
    logic            word_valid;
    logic [31:0]     word_data;
    logic            last_word;

    assign accept     = in_valid && in_ready;
    assign start_load = start && !busy;
    assign frame_len  = {in_data, len_lo};
    assign last_word  = word_valid && ((words_loaded + 1'b1) == len_words);

    imem_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_load),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        case (state)
            IDLE, DONE, ERROR: if (start) state_n = LEN0;
            LEN0: if (accept) state_n = LEN1;
            LEN1: begin
                if (accept) begin
                    if (frame_len > 16'(IMEM_WORDS)) state_n = ERROR;
                    else if (frame_len == 16'd0)     state_n = CSUM;
                    else                             state_n = DATA;
                end
            end
            DATA: if (last_word) state_n = CSUM;
            CSUM: if (accept) state_n = (in_data == xor_acc) ? DONE : ERROR;
            default: state_n = IDLE;
        endcase
        case (state)
            LEN0, LEN1, DATA, CSUM: busy = 1'b1;
            DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            ERROR: error = 1'b1;
            default: ;
        endcase
        in_ready = busy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            words_loaded <= '0;
            xor_acc      <= 8'd0;
            len_lo       <= 8'd0;
            len_words    <= '0;
        end else begin
            imem_we <= word_valid;
            if (word_valid) begin
                imem_wdata   <= word_data;
                words_loaded <= words_loaded + 1'b1;
            end
            // Saturate on the last slot so a full-depth image leaves the index in range.
            if (imem_we && (imem_addr != ADDR_W'(IMEM_WORDS - 1)))
                imem_addr <= imem_addr + 1'b1;
            if (accept && (state != CSUM))
                xor_acc <= xor_acc ^ in_data;
            if (accept && (state == LEN0))
                len_lo <= in_data;
            if (accept && (state == LEN1))
                len_words <= frame_len[ADDR_W:0];
            if (start_load) begin
                imem_addr    <= '0;
                words_loaded <= '0;
                xor_acc      <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        int         nbytes;
        logic [7:0] b [16];
        bit         gaps;
        int         mid_start;
        bit         exp_done;
        bit         exp_err;
        int         exp_words;
    } vec_t;

    vec_t vecs[5];

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (imem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                check("imem_write", {24'd0, imem_addr, imem_wdata}, sb_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hff;
        check("in_ready_at_start", in_ready, 1'b0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_done", done, 1'b0);
        check("start_error", error, 1'b0);
        check("start_cpu_reset", cpu_reset, 1'b1);
        check("start_words", words_loaded, 9'd0);
    endtask

    task automatic push_word(input int k, input logic [31:0] w);
        sb_q.push_back({24'd0, 8'(k), w});
    endtask

    task automatic run_vec(input int idx);
        int          n;
        logic [31:0] w;
        do_start();
        n = {vecs[idx].b[1], vecs[idx].b[0]};
        w = 32'd0;
        for (int i = 0; i < vecs[idx].nbytes; i++) begin
            if (vecs[idx].gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i == vecs[idx].mid_start) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("start_ignored", busy, 1'b1);
            end
            if (n <= 256 && i >= FRAME_HDR_BYTES && i < FRAME_HDR_BYTES + 4 * n) begin
                w[8 * ((i - FRAME_HDR_BYTES) % 4) +: 8] = vecs[idx].b[i];
                if ((i - FRAME_HDR_BYTES) % 4 == 3) push_word((i - FRAME_HDR_BYTES) / 4, w);
            end
            send_byte(vecs[idx].b[i]);
        end
        @(negedge clk);
        check($sformatf("v%0d_done", idx), done, vecs[idx].exp_done);
        check($sformatf("v%0d_error", idx), error, vecs[idx].exp_err);
        check($sformatf("v%0d_cpu_reset", idx), cpu_reset, !vecs[idx].exp_done);
        check($sformatf("v%0d_busy", idx), busy, 1'b0);
        check($sformatf("v%0d_in_ready", idx), in_ready, 1'b0);
        check($sformatf("v%0d_words", idx), words_loaded, 9'(vecs[idx].exp_words));
        check($sformatf("v%0d_sb_empty", idx), sb_q.size(), 0);
    endtask

    initial begin
        logic [7:0]  big_x;
        logic [7:0]  rb;
        logic [31:0] w;

        vecs[0].nbytes = 11;
        vecs[0].b = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                      8'h10, 8'h00, 8'h92, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[0].gaps = 0; vecs[0].mid_start = -1;
        vecs[0].exp_done = 1; vecs[0].exp_err = 0; vecs[0].exp_words = 2;

        vecs[1] = vecs[0];
        vecs[1].b[10] = 8'h00;
        vecs[1].exp_done = 0; vecs[1].exp_err = 1;

        vecs[2].nbytes = 2;
        vecs[2].b = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].gaps = 0; vecs[2].mid_start = -1;
        vecs[2].exp_done = 0; vecs[2].exp_err = 1; vecs[2].exp_words = 0;

        vecs[3].nbytes = 3;
        vecs[3].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].gaps = 0; vecs[3].mid_start = -1;
        vecs[3].exp_done = 1; vecs[3].exp_err = 0; vecs[3].exp_words = 0;

        vecs[4] = vecs[0];
        vecs[4].gaps = 1; vecs[4].mid_start = 5;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_imem_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, 8'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_words", words_loaded, 9'd0);

        for (int v = 0; v < 5; v++) run_vec(v);

        // Reset in the middle of a load.
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        push_word(0, 32'h00000013);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h93);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_imem_we", imem_we, 1'b0);
        check("mid_rst_addr", imem_addr, 8'd0);
        check("mid_rst_wdata", imem_wdata, 32'd0);
        check("mid_rst_cpu_reset", cpu_reset, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_error", error, 1'b0);
        check("mid_rst_words", words_loaded, 9'd0);
        check("mid_rst_sb_empty", sb_q.size(), 0);
        reset = 1'b0;
        @(negedge clk);
        run_vec(0);

        // Full-depth image: 256 random words.
        do_start();
        big_x = 8'h00 ^ 8'h01;
        send_byte(8'h00);
        send_byte(8'h01);
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 4; j++) begin
                rb = 8'($urandom_range(0, 255));
                w[8 * j +: 8] = rb;
                big_x = big_x ^ rb;
                if (j == 3) push_word(k, w);
                send_byte(rb);
            end
        end
        send_byte(big_x);
        @(negedge clk);
        check("full_done", done, 1'b1);
        check("full_words", words_loaded, 9'd256);
        check("full_addr_no_wrap", imem_addr, 8'd255);
        check("full_sb_empty", sb_q.size(), 0);

        // Zero-length image, then restart from DONE.
        run_vec(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_done", done, 1'b0);
        check("restart_cpu_reset", cpu_reset, 1'b1);
        check("restart_busy", busy, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
